// File: rtl/data_memory_unit_if.sv
// Load/store bus between the control unit (master) and the data memory (slave).
// Carries the access request, the combinational load result and the sticky fault state.
interface data_memory_unit_if #(
    parameter int unsigned FCNT_W = 8
);
    logic [31:0]       Address;
    logic [31:0]       DataWr;
    logic              DMWr;
    logic              DMRd;
    logic [2:0]        DMCtrl;
    logic [31:0]       DataRd;
    logic              MisalignFault;
    logic [31:0]       FaultAddr;
    logic [FCNT_W-1:0] FaultCount;

    modport master (
        output Address, DataWr, DMWr, DMRd, DMCtrl,
        input  DataRd, MisalignFault, FaultAddr, FaultCount
    );

    modport slave (
        input  Address, DataWr, DMWr, DMRd, DMCtrl,
        output DataRd, MisalignFault, FaultAddr, FaultCount
    );
endinterface

// File: rtl/data_memory_unit.sv
// RV32I data memory: synchronous lane-masked stores, combinational extended loads,
// and sticky fault capture for misaligned or illegal accesses.
module data_memory_unit #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FCNT_W      = 8
) (
    input logic               clk,
    input logic               rst,
    data_memory_unit_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]       mem [DEPTH_WORDS];
    logic [AW-1:0]     widx;
    logic [1:0]        boff;

    logic              ld_legal;
    logic              st_legal;
    logic              misaligned;
    logic              fault_wr;
    logic              fault_rd;
    logic              fault;
    logic              wr_en;
    logic [3:0]        be;
    logic [31:0]       wdata;

    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       rd_data;

    logic              fault_q;
    logic [31:0]       addr_q;
    logic [FCNT_W-1:0] count_q;

    assign widx = bus.Address[AW+1:2];
    assign boff = bus.Address[1:0];

    // Unsigned encodings are load-only; 011/110/111 are illegal in both directions.
    always_comb begin
        ld_legal   = 1'b0;
        st_legal   = 1'b0;
        misaligned = 1'b0;
        case (bus.DMCtrl)
            3'b000: begin
                ld_legal = 1'b1;
                st_legal = 1'b1;
            end
            3'b001: begin
                ld_legal   = 1'b1;
                st_legal   = 1'b1;
                misaligned = boff[0];
            end
            3'b010: begin
                ld_legal   = 1'b1;
                st_legal   = 1'b1;
                misaligned = |boff;
            end
            3'b100: ld_legal = 1'b1;
            3'b101: begin
                ld_legal   = 1'b1;
                misaligned = boff[0];
            end
            default: ;
        endcase
    end

    assign fault_wr = bus.DMWr & (~st_legal | misaligned);
    assign fault_rd = bus.DMRd & (~ld_legal | misaligned);
    assign fault    = fault_wr | fault_rd;
    assign wr_en    = bus.DMWr & ~fault_wr & ~rst;

    always_comb begin
        be    = 4'b0000;
        wdata = bus.DataWr;
        case (bus.DMCtrl[1:0])
            2'b00: begin
                be[boff] = 1'b1;
                wdata    = {4{bus.DataWr[7:0]}};
            end
            2'b01: begin
                be    = boff[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.DataWr[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd_word = mem[widx];
    assign rd_byte = rd_word[{boff, 3'b000} +: 8];
    assign rd_half = boff[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rd_data = 32'h0;
        if (bus.DMRd && !fault_rd) begin
            case (bus.DMCtrl)
                3'b000:  rd_data = {{24{rd_byte[7]}}, rd_byte};
                3'b001:  rd_data = {{16{rd_half[15]}}, rd_half};
                3'b010:  rd_data = rd_word;
                3'b100:  rd_data = {24'h0, rd_byte};
                3'b101:  rd_data = {16'h0, rd_half};
                default: rd_data = 32'h0;
            endcase
        end
    end

    // Reset wins over capture; only the first fault since reset records its address.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
            addr_q  <= 32'h0;
            count_q <= '0;
        end else if (fault) begin
            fault_q <= 1'b1;
            if (!fault_q) begin
                addr_q <= bus.Address;
            end
            if (count_q != {FCNT_W{1'b1}}) begin
                count_q <= count_q + FCNT_W'(1);
            end
        end
    end

    assign bus.DataRd        = rd_data;
    assign bus.MisalignFault = fault_q;
    assign bus.FaultAddr     = addr_q;
    assign bus.FaultCount    = count_q;
endmodule
